// File: rtl/uart_cmd_rx_pkg.sv
// Shared definitions for the command-path UART.
//   CLK_PER_BIT_DEF : default bit period in clk cycles (50 MHz / 1 Mbaud);
//                     the matching transmitter uses the same value.
//   state_t         : receiver FSM state encoding.
package uart_cmd_rx_pkg;

  localparam int unsigned CLK_PER_BIT_DEF = 50;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

endpackage

// File: rtl/uart_cmd_rx_bit_sync.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk : destination clock
//   rst : asynchronous active-high reset; both flops load RST_VAL
//   d   : asynchronous input
//   q   : synchronised output (two clk cycles of latency)
module uart_cmd_rx_bit_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART receiver (8N1, LSB first) feeding the command decoder.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   rx        : serial line, asynchronous to clk, idles high
//   data      : last correctly framed byte
//   new_data  : 1-cycle strobe, data updated this cycle
//   frame_err : 1-cycle strobe, stop bit sampled low
//   busy      : high whenever the FSM is not idle
module uart_cmd_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter  int unsigned CLK_PER_BIT = CLK_PER_BIT_DEF,
  localparam int unsigned CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       new_data,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CTR_SIZE-1:0] HALF_M1 = CTR_SIZE'(CLK_PER_BIT / 2 - 1);
  localparam logic [CTR_SIZE-1:0] BIT_M1  = CTR_SIZE'(CLK_PER_BIT - 1);

  logic                rx_s;
  state_t              state, state_n;
  logic [CTR_SIZE-1:0] ctr, ctr_n;
  logic [2:0]          bit_idx, bit_idx_n;
  logic [7:0]          shreg, shreg_n;
  logic [7:0]          data_n;
  logic                new_data_n, frame_err_n;

  uart_cmd_rx_bit_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ctr       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      new_data  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      ctr       <= ctr_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      data      <= data_n;
      new_data  <= new_data_n;
      frame_err <= frame_err_n;
      // Registered from the next state so busy tracks the state register exactly.
      busy      <= (state_n != ST_IDLE);
    end
  end

  always_comb begin
    state_n     = state;
    ctr_n       = ctr + 1'b1;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    data_n      = data;
    new_data_n  = 1'b0;
    frame_err_n = 1'b0;

    case (state)
      ST_IDLE: begin
        ctr_n = '0;
        if (!rx_s) state_n = ST_START;
      end

      // Re-check the line at mid start bit; a short low pulse is a glitch.
      ST_START: begin
        if (ctr == HALF_M1) begin
          ctr_n = '0;
          if (!rx_s) begin
            state_n   = ST_DATA;
            bit_idx_n = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (ctr == BIT_M1) begin
          ctr_n     = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = ST_STOP;
        end
      end

      // Leaving at mid stop bit lets a back-to-back start edge be caught.
      ST_STOP: begin
        if (ctr == BIT_M1) begin
          ctr_n = '0;
          if (rx_s) begin
            data_n     = shreg;
            new_data_n = 1'b1;
            state_n    = ST_IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = ST_WAIT_IDLE;
          end
        end
      end

      // A held-low line (break) must produce only one frame_err.
      ST_WAIT_IDLE: begin
        ctr_n = '0;
        if (rx_s) state_n = ST_IDLE;
      end

      default: begin
        ctr_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
module tb_uart_cmd_rx;

  localparam int unsigned CPB     = 50;
  localparam int unsigned H       = CPB / 2;
  localparam int unsigned LATENCY = 2 + H + 9 * CPB;

  typedef struct {
    logic [7:0]  data;
    int unsigned exp_cyc;
    bit          chk_lat;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       new_data;
  logic       frame_err;
  logic       busy;

  bit          clk_run = 1'b1;
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  sb_t         sb_q[$];
  int unsigned nd_cnt = 0;
  int unsigned fe_cnt = 0;
  int unsigned nd_cyc_prev = 0;
  int unsigned nd_cyc_last = 0;
  bit          busy_seen = 1'b0;
  bit          prev_nd = 1'b0;
  bit          busy_chk_next = 1'b0;

  uart_cmd_rx #(.CLK_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .new_data  (new_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Must be called right after a falling clk edge.
  task automatic send_byte(input logic [7:0] b, input int unsigned bitlen, input bit chk_lat);
    sb_t e;
    e.data    = b;
    e.exp_cyc = cyc + 1 + LATENCY;
    e.chk_lat = chk_lat;
    sb_q.push_back(e);
    rx = 1'b0;
    repeat (bitlen) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bitlen) @(negedge clk);
    end
    rx = 1'b1;
    repeat (bitlen) @(negedge clk);
  endtask

  // Output monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_seen = 1'b1;
      if (busy_chk_next) begin
        chk("busy_after_strobe", {31'b0, busy}, 32'd0);
        busy_chk_next = 1'b0;
      end
      if (frame_err) fe_cnt++;
      if (new_data) begin
        sb_t e;
        nd_cnt++;
        nd_cyc_prev = nd_cyc_last;
        nd_cyc_last = cyc;
        chk("strobe_overlap", {31'b0, frame_err}, 32'd0);
        chk("strobe_double", {31'b0, prev_nd}, 32'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_byte", {24'b0, data}, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("rx_data", {24'b0, data}, {24'b0, e.data});
          if (e.chk_lat) chk("rx_latency", cyc, e.exp_cyc);
        end
        busy_chk_next = 1'b1;
      end
      prev_nd = new_data;
    end
  end

  initial begin
    int unsigned nd0, fe0;

    // 1: reset and idle
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    chk("rst_data", {24'b0, data}, 32'd0);
    chk("rst_new_data", {31'b0, new_data}, 32'd0);
    chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2000) @(negedge clk);
    chk("idle_new_data", nd_cnt, 32'd0);
    chk("idle_frame_err", fe_cnt, 32'd0);
    chk("idle_busy", {31'b0, busy_seen}, 32'd0);

    // 2: single 'd'
    send_byte(8'h64, CPB, 1'b1);
    repeat (50) @(negedge clk);
    chk("d_count", nd_cnt, 32'd1);
    chk("d_frame_err", fe_cnt, 32'd0);

    // 3: 's' then 'p' back-to-back
    send_byte(8'h73, CPB, 1'b1);
    send_byte(8'h70, CPB, 1'b1);
    repeat (100) @(negedge clk);
    chk("sp_count", nd_cnt, 32'd3);
    chk("sp_gap", nd_cyc_last - nd_cyc_prev, 32'd500);
    chk("sp_data", {24'b0, data}, 32'h70);

    // 4: short glitch
    nd0 = nd_cnt;
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy_rise", {31'b0, busy}, 32'd1);
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (H + 3 - 10) @(negedge clk);
    chk("glitch_busy_fall", {31'b0, busy}, 32'd0);
    repeat (200) @(negedge clk);
    chk("glitch_new_data", nd_cnt - nd0, 32'd0);
    chk("glitch_frame_err", fe_cnt - fe0, 32'd0);

    // 5: break, then normal byte
    nd0 = nd_cnt;
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("break_frame_err", fe_cnt - fe0, 32'd1);
    chk("break_new_data", nd_cnt - nd0, 32'd0);
    chk("break_data_kept", {24'b0, data}, 32'h70);
    send_byte(8'h41, CPB, 1'b1);
    repeat (100) @(negedge clk);
    chk("post_break_count", nd_cnt - nd0, 32'd1);

    // 6: async reset mid-DATA with the clock stopped
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    chk("mid_frame_busy", {31'b0, busy}, 32'd1);
    clk_run = 1'b0;
    #20;
    rst = 1'b1;
    #1;
    chk("async_rst_data", {24'b0, data}, 32'd0);
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    chk("async_rst_new_data", {31'b0, new_data}, 32'd0);
    chk("async_rst_frame_err", {31'b0, frame_err}, 32'd0);
    #20;
    rst = 1'b0;
    clk_run = 1'b1;
    @(negedge clk);
    nd0 = nd_cnt;
    fe0 = fe_cnt;
    repeat (12 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    send_byte(8'h41, CPB, 1'b1);
    repeat (100) @(negedge clk);
    chk("rst_recover_count", nd_cnt - nd0, 32'd1);
    chk("rst_recover_data", {24'b0, data}, 32'h41);
    chk("rst_recover_fe_le1", {31'b0, (fe_cnt - fe0) <= 1}, 32'd1);

    // 7: skewed bit periods
    nd0 = nd_cnt;
    fe0 = fe_cnt;
    send_byte(8'h55, 48, 1'b0);
    repeat (100) @(negedge clk);
    send_byte(8'hAA, 52, 1'b0);
    repeat (100) @(negedge clk);
    chk("skew_count", nd_cnt - nd0, 32'd2);
    chk("skew_frame_err", fe_cnt - fe0, 32'd0);
    chk("skew_data", {24'b0, data}, 32'hAA);

    chk("sb_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
